pulse_train_gen: RTL and testbench



---
 rtl/pulse_gen_pkg.sv | 40 ++++
 rtl/pulse_cfg_sanitise.sv | 34 +++
 rtl/pulse_train_gen.sv | 161 ++++++++++++++++
 tb/tb_pulse_train_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types for pulse_train_gen: FSM state encoding, raw and sanitised
// burst configuration. Module CNT_W/BURST_W must not exceed the maxima here.
package pulse_gen_pkg;

    localparam int unsigned CNT_W_MAX   = 16;
    localparam int unsigned BURST_W_MAX = 4;
    localparam int unsigned IV_W        = CNT_W_MAX + 1;
    localparam int unsigned PER_W       = CNT_W_MAX + BURST_W_MAX + 1;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_DELAY_ENC = 3'd1;
    localparam logic [2:0] ST_HIGH_ENC  = 3'd2;
    localparam logic [2:0] ST_GAP_ENC   = 3'd3;
    localparam logic [2:0] ST_REST_ENC  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_DELAY = ST_DELAY_ENC,
        ST_HIGH  = ST_HIGH_ENC,
        ST_GAP   = ST_GAP_ENC,
        ST_REST  = ST_REST_ENC
    } state_t;

    typedef struct packed {
        logic [CNT_W_MAX-1:0]   d;
        logic [CNT_W_MAX-1:0]   p;
        logic [CNT_W_MAX-1:0]   w;
        logic [CNT_W_MAX-1:0]   i;
        logic [BURST_W_MAX-1:0] b;
    } raw_cfg_t;

    typedef struct packed {
        logic [CNT_W_MAX-1:0]   d;
        logic [PER_W-1:0]       p;
        logic [CNT_W_MAX-1:0]   w;
        logic [IV_W-1:0]        i;
        logic [BURST_W_MAX-1:0] b;
    } san_cfg_t;

endpackage

// File: rtl/pulse_cfg_sanitise.sv
// Combinational clean-up of a latched burst configuration so the FSM never
// sees a zero width, zero count, overlapping pulses or a too-short period.
module pulse_cfg_sanitise
    import pulse_gen_pkg::*;
(
    input  raw_cfg_t i_raw,
    output san_cfg_t o_cfg
);

    logic [CNT_W_MAX-1:0]   w_w;
    logic [BURST_W_MAX-1:0] w_b;
    logic [BURST_W_MAX-1:0] w_bm1;
    logic [IV_W-1:0]        w_i;
    logic [PER_W-1:0]       w_min_p;

    always_comb begin
        w_w     = (i_raw.w == '0) ? CNT_W_MAX'(1) : i_raw.w;
        w_b     = (i_raw.b == '0) ? BURST_W_MAX'(1) : i_raw.b;
        w_bm1   = w_b - BURST_W_MAX'(1);
        w_i     = {1'b0, i_raw.i};
        if ((w_b > BURST_W_MAX'(1)) && (i_raw.i <= w_w)) begin
            w_i = {1'b0, w_w} + IV_W'(1);
        end
        // Shortest period that still leaves one low cycle after the last pulse
        w_min_p = PER_W'(w_bm1) * PER_W'(w_i) + PER_W'(w_w) + PER_W'(1);

        o_cfg.d = i_raw.d;
        o_cfg.w = w_w;
        o_cfg.i = w_i;
        o_cfg.b = w_b;
        o_cfg.p = (PER_W'(i_raw.p) < w_min_p) ? w_min_p : PER_W'(i_raw.p);
    end

endmodule

// File: rtl/pulse_train_gen.sv
// Periodic pulse/burst generator with programmable delay, period, width,
// intra-burst interval and burst count; continuous or one-shot.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_MAX,
    parameter int unsigned BURST_W = BURST_W_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [CNT_W-1:0]   cfg_delay,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_width,
    input  logic [CNT_W-1:0]   cfg_interval,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               cfg_oneshot,
    output logic               sig_out,
    output logic               busy,
    output logic               period_start
);

    localparam int unsigned PH_W = IV_W;

    state_t                 r_state;
    state_t                 w_state_nxt;
    raw_cfg_t               r_cfg;
    raw_cfg_t               w_raw_in;
    san_cfg_t               w_cfg;
    logic                   r_oneshot;
    logic [PH_W-1:0]        r_phase;
    logic [PER_W-1:0]       r_per;
    logic [BURST_W_MAX-1:0] r_idx;
    logic                   r_sig_out;
    logic                   r_busy;
    logic                   r_period_start;
    logic                   w_latch;
    logic                   w_burst_start;
    logic                   w_more;
    logic [PH_W-1:0]        w_gap_len;

    always_comb begin
        w_raw_in.d = CNT_W_MAX'(cfg_delay);
        w_raw_in.p = CNT_W_MAX'(cfg_period);
        w_raw_in.w = CNT_W_MAX'(cfg_width);
        w_raw_in.i = CNT_W_MAX'(cfg_interval);
        w_raw_in.b = BURST_W_MAX'(cfg_burst);
    end

    pulse_cfg_sanitise u_sanitise (
        .i_raw (r_cfg),
        .o_cfg (w_cfg)
    );

    assign w_more    = (r_idx + BURST_W_MAX'(1)) < w_cfg.b;
    assign w_gap_len = w_cfg.i - PH_W'(w_cfg.w);

    always_comb begin
        w_state_nxt   = r_state;
        w_latch       = 1'b0;
        w_burst_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Raw delay decides here: a zero delay goes straight to the first pulse
                if (en) begin
                    w_latch = 1'b1;
                    if (cfg_delay == '0) begin
                        w_state_nxt   = ST_HIGH;
                        w_burst_start = 1'b1;
                    end else begin
                        w_state_nxt = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                if (r_phase >= PH_W'(w_cfg.d)) begin
                    w_state_nxt   = ST_HIGH;
                    w_burst_start = 1'b1;
                end
            end
            ST_HIGH: begin
                if (r_phase >= PH_W'(w_cfg.w)) begin
                    if (w_more) begin
                        w_state_nxt = ST_GAP;
                    end else if (!r_oneshot && en) begin
                        w_state_nxt = ST_REST;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (r_phase >= w_gap_len) begin
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_REST: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_per >= w_cfg.p) begin
                    w_state_nxt   = ST_HIGH;
                    w_latch       = 1'b1;
                    w_burst_start = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cfg          <= '0;
            r_oneshot      <= 1'b0;
            r_phase        <= '0;
            r_per          <= '0;
            r_idx          <= '0;
            r_sig_out      <= 1'b0;
            r_busy         <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_cfg     <= w_raw_in;
                r_oneshot <= cfg_oneshot;
            end

            // Phase counts cycles within DELAY/HIGH/GAP; REST is timed by r_per
            if (w_state_nxt == ST_IDLE) begin
                r_phase <= '0;
            end else if (w_state_nxt != r_state) begin
                r_phase <= PH_W'(1);
            end else if (r_state != ST_REST) begin
                r_phase <= r_phase + PH_W'(1);
            end

            if (w_burst_start) begin
                r_per <= PER_W'(1);
            end else if (w_state_nxt == ST_IDLE) begin
                r_per <= '0;
            end else if (r_state inside {ST_HIGH, ST_GAP, ST_REST}) begin
                r_per <= r_per + PER_W'(1);
            end

            if (w_burst_start || (w_state_nxt == ST_IDLE)) begin
                r_idx <= '0;
            end else if ((r_state == ST_HIGH) && (w_state_nxt == ST_GAP)) begin
                r_idx <= r_idx + BURST_W_MAX'(1);
            end

            r_sig_out      <= (w_state_nxt == ST_HIGH);
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_period_start <= w_burst_start;
        end
    end

    assign sig_out      = r_sig_out;
    assign busy         = r_busy;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed timing cases plus randomized config/enable
// traffic checked every cycle against a burst-schedule reference model.
module tb_pulse_train_gen;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BURST_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [CNT_W-1:0]   cfg_delay;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_width;
    logic [CNT_W-1:0]   cfg_interval;
    logic [BURST_W-1:0] cfg_burst;
    logic               cfg_oneshot;
    logic               sig_out;
    logic               busy;
    logic               period_start;

    pulse_train_gen #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_delay    (cfg_delay),
        .cfg_period   (cfg_period),
        .cfg_width    (cfg_width),
        .cfg_interval (cfg_interval),
        .cfg_burst    (cfg_burst),
        .cfg_oneshot  (cfg_oneshot),
        .sig_out      (sig_out),
        .busy         (busy),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   t        = 0;
    int   t0       = 0;
    logic h_sig  [0:255];
    logic h_busy [0:255];
    logic h_ps   [0:255];

    // Reference model: a running sequence is described by the start cycle of the
    // current burst and that burst's sanitised parameters.
    bit   m_run = 1'b0;
    int   m_s, m_p, m_w, m_i, m_b;
    bit   m_os;
    logic exp_sig, exp_busy, exp_ps;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", tag, t, got, exp);
        end
    endtask

    task automatic latch_cfg();
        int w, b, i, p, minp;
        w = (cfg_width == '0) ? 1 : int'(cfg_width);
        b = (cfg_burst == '0) ? 1 : int'(cfg_burst);
        i = int'(cfg_interval);
        if (b > 1 && i <= w) i = w + 1;
        minp = (b - 1) * i + w + 1;
        p = int'(cfg_period);
        if (p < minp) p = minp;
        m_w = w; m_b = b; m_i = i; m_p = p; m_os = cfg_oneshot;
    endtask

    function automatic bit in_pulse(int u);
        int off;
        if (u < m_s) return 1'b0;
        off = u - m_s;
        if (m_b == 1) return off < m_w;
        return ((off / m_i) < m_b) && ((off % m_i) < m_w);
    endfunction

    function automatic int last_high();
        return m_s + (m_b - 1) * m_i + m_w - 1;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (en) begin
                latch_cfg();
                m_s   = t + 1 + int'(cfg_delay);
                m_run = 1'b1;
            end
        end else if (t == last_high()) begin
            if (m_os || !en) m_run = 1'b0;
        end else if (t > last_high()) begin
            if (!en) begin
                m_run = 1'b0;
            end else if (t == m_s + m_p - 1) begin
                latch_cfg();
                m_s = t + 1;
            end
        end
        exp_sig  = m_run && in_pulse(t + 1);
        exp_busy = m_run;
        exp_ps   = m_run && (t + 1 == m_s);
    endtask

    task automatic tick();
        int rel;
        model_step();
        @(negedge clk);
        t++;
        chk("sig_out", sig_out, exp_sig);
        chk("busy", busy, exp_busy);
        chk("period_start", period_start, exp_ps);
        rel = t - t0;
        if (rel >= 0 && rel < 256) begin
            h_sig[rel]  = sig_out;
            h_busy[rel] = busy;
            h_ps[rel]   = period_start;
        end
    endtask

    task automatic start_case(input int d, input int p, input int w,
                              input int i, input int b, input bit os);
        rst          = 1'b1;
        en           = 1'b0;
        cfg_delay    = CNT_W'(d);
        cfg_period   = CNT_W'(p);
        cfg_width    = CNT_W'(w);
        cfg_interval = CNT_W'(i);
        cfg_burst    = BURST_W'(b);
        cfg_oneshot  = os;
        tick();
        rst = 1'b0;
        tick();
        en = 1'b1;
        t0 = t;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=running required=finished", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; cfg_delay = '0; cfg_period = '0; cfg_width = '0;
        cfg_interval = '0; cfg_burst = '0; cfg_oneshot = 1'b0;
        tick();
        chk("reset_sig", sig_out, 1'b0);
        chk("reset_busy", busy, 1'b0);

        // D=0 P=10 W=2 B=1 continuous
        start_case(0, 10, 2, 0, 1, 1'b0);
        repeat (25) tick();
        for (int r = 1; r <= 24; r++) begin
            chk("c1_sig", h_sig[r], ((r - 1) % 10) < 2);
            chk("c1_ps", h_ps[r], ((r - 1) % 10) == 0);
        end

        // Doubled pulse: D=1 P=100 W=2 I=5 B=2
        start_case(1, 100, 2, 5, 2, 1'b0);
        repeat (110) tick();
        for (int r = 1; r <= 109; r++) begin
            chk("c2_sig", h_sig[r], r inside {2, 3, 7, 8, 102, 103, 107, 108});
            chk("c2_ps", h_ps[r], r inside {2, 102});
        end

        // One-shot: D=4 W=1 I=3 B=3 P=20, en pulsed for one cycle
        start_case(4, 20, 1, 3, 3, 1'b1);
        tick();
        en = 1'b0;
        repeat (29) tick();
        for (int r = 1; r <= 29; r++) begin
            chk("c3_sig", h_sig[r], r inside {5, 8, 11});
            chk("c3_busy", h_busy[r], r <= 11);
        end

        // Sanitisation: W=0 I=0 B=2 P=1 -> W=1 I=2 P=4
        start_case(0, 1, 0, 0, 2, 1'b0);
        repeat (21) tick();
        for (int r = 1; r <= 20; r++) begin
            chk("c4_sig", h_sig[r], (r % 2) == 1);
            chk("c4_ps", h_ps[r], ((r - 1) % 4) == 0);
        end

        // Reset during HIGH with en held: restart with full delay
        start_case(3, 10, 3, 0, 1, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("c5_pre_sig", h_sig[5], 1'b1);
        chk("c5_rst_sig", h_sig[6], 1'b0);
        chk("c5_rst_busy", h_busy[6], 1'b0);
        chk("c5_restart_busy", h_busy[7], 1'b1);
        chk("c5_delay_sig", h_sig[9], 1'b0);
        chk("c5_first_sig", h_sig[10], 1'b1);
        chk("c5_first_ps", h_ps[10], 1'b1);

        // Width change 2->4 mid-burst takes effect at next period boundary
        start_case(0, 10, 2, 0, 1, 1'b0);
        repeat (3) tick();
        cfg_width = CNT_W'(4);
        repeat (22) tick();
        for (int r = 1; r <= 24; r++) begin
            chk("c6_sig", h_sig[r], r inside {[1:2], [11:14], [21:24]});
        end

        // Randomized config, enable and occasional reset traffic
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(7) == 0) begin
                cfg_delay    = CNT_W'($urandom_range(6));
                cfg_period   = CNT_W'($urandom_range(40));
                cfg_width    = CNT_W'($urandom_range(6));
                cfg_interval = CNT_W'($urandom_range(9));
                cfg_burst    = BURST_W'($urandom_range(5));
                cfg_oneshot  = ($urandom_range(3) == 0);
            end
            if ($urandom_range(15) == 0) en = ~en;
            rst = ($urandom_range(299) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
